fc_event_serializer: RTL and testbench
======================================

Name: fc_event_serializer

Overview:
- Upstream neighbour of the FC event unit. Collects single-cycle SoC event pulses from NB_SOURCES peripherals and serializes them into event IDs.
- Feeds the FC event FIFO push port (valid / fulln / data) that drives the core's FIFO-based interrupts.
- Per-source saturating pending counters keep bursts from being lost while the FIFO is full. A round-robin arbiter gives fair service.

Parameters:
- NB_SOURCES, 8, number of event pulse inputs (1..32).
- EVENT_ID_WIDTH, 8, width of the emitted event ID. Must match the event FIFO data width.
- ID_BASE, 0, ID of source 0. Source i emits ID_BASE+i. Elaboration error if ID_BASE+NB_SOURCES > 2**EVENT_ID_WIDTH.
- PEND_CNT_WIDTH, 2, per-source pending counter width. Maximum pending count is 2**PEND_CNT_WIDTH-1.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset. Asynchronous, active-high.
- evt_i, in, NB_SOURCES, event pulses; each bit high for one cycle per event.
- event_fifo_valid_o, out, 1, event ID valid toward the event FIFO.
- event_fifo_data_o, out, EVENT_ID_WIDTH, event ID.
- event_fifo_fulln_i, in, 1, FIFO not full. A transfer occurs when valid_o && fulln_i.
- overflow_o, out, 1, one-cycle pulse: an event was dropped.
- ovf_src_o, out, EVENT_ID_WIDTH, ID of the dropped source. Valid while overflow_o=1.
- ovf_status_o, out, NB_SOURCES, sticky per-source overflow flags (optional feature).
- ovf_clr_i, in, NB_SOURCES, write-1-clear for ovf_status_o (optional feature).

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - all counters = 0; event_fifo_valid_o = 0; event_fifo_data_o = 0.
  - overflow_o = 0; ovf_src_o = 0; ovf_status_o = 0; RR pointer = 0.
  - Pending events are discarded.
- Counter update per source i, each cycle:
  - cnt_i_next = cnt_i + evt_i[i] - grant_i.
  - grant_i = 1 when source i is loaded into the output register this cycle.
  - If evt_i[i] and grant_i occur together, the count is unchanged.
  - If evt_i[i]=1, cnt_i = max and grant_i = 0, the counter holds at max and the event is dropped (overflow).
- Arbiter:
  - Combinational round-robin over sources with cnt != 0.
  - Search starts at (last granted index + 1) mod NB_SOURCES.
  - The RR pointer updates only on a grant.
- Output register is a single stage. It can load when (!valid_o) || fulln_i:
  - if any counter != 0: load ID_BASE+winner, valid_o=1, decrement the winner's counter.
  - otherwise valid_o=0. The data value is don't-care but holds its last value.
- Handshake:
  - While valid_o && !fulln_i, valid_o and data_o are held stable. No new grant occurs.
  - valid_o never deasserts without a transfer (except on reset).
- Latency:
  - evt_i pulse in cycle N, idle block, fulln=1 → counter=1 at N+1 → valid_o=1 with the ID in cycle N+2.
- Throughput: one ID per cycle while fulln_i=1 and events are pending.
- Events are never reordered within one source. Inter-source order follows RR.
- Overflow reporting:
  - Registered: drop in cycle N → overflow_o=1 in N+1.
  - If several sources drop in the same cycle, ovf_src_o = lowest dropped index + ID_BASE.
  - overflow_o is a single-cycle pulse per dropping cycle.

Optional Feature:
- Macro: FC_EVT_SER_OVF_STICKY_EN.
- Defined:
  - ovf_status_o[i] sets on any drop from source i.
  - It clears when ovf_clr_i[i]=1.
  - A set and clear in the same cycle leaves it set (set wins).
- Undefined:
  - ovf_status_o is tied to 0 and ovf_clr_i is ignored.
  - overflow_o and ovf_src_o behave identically in both builds.

Test Plan:
- Single event: evt_i[3] pulse at cycle 10, fulln=1, ID_BASE=0 → valid_o=1, data=3 at cycle 12 only; valid_o=0 at cycle 13.
- Round-robin: evt_i=8'hFF in one cycle, fulln=1 → IDs 0,1,2,...,7 on consecutive cycles. Then evt_i[0] and evt_i[7] together → 0 then 7 (pointer after 7 wraps to 0).
- Backpressure: fulln=0 while evt_i[2] pulses 3 times → valid_o=1, data=2 held stable. Release fulln → three transfers of ID 2, then valid_o=0.
- Overflow (PEND_CNT_WIDTH=2): fulln=0, then 5 pulses on evt_i[5].
  - Counter reaches 3 after the first pulse enters the output register.
  - 5th pulse: overflow_o=1 for one cycle, ovf_src_o=5.
  - Release fulln → exactly 4 transfers of ID 5.
- Simultaneous increment/grant: source 1 at cnt=1 while evt_i[1] pulses in its grant cycle → cnt stays 1, no overflow, two transfers of ID 1 total.
- Reset mid-operation: assert rst_i while valid_o=1 and counters are non-zero → valid_o=0 immediately, with no clock edge required. After deassertion no stale IDs are emitted. With FC_EVT_SER_OVF_STICKY_EN, ovf_status_o=0.

Source files
------------

// File: rtl/fc_event_serializer.sv
// SoC event pulse serializer: per-source saturating counters, RR arbiter, one-stage output.
// Optional sticky overflow flags enabled by defining FC_EVT_SER_OVF_STICKY_EN.
module fc_event_serializer #(
  parameter int NB_SOURCES     = 8,
  parameter int EVENT_ID_WIDTH = 8,
  parameter int ID_BASE        = 0,
  parameter int PEND_CNT_WIDTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_SOURCES-1:0]     evt_i,
  output logic                      event_fifo_valid_o,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  input  logic                      event_fifo_fulln_i,
  output logic                      overflow_o,
  output logic [EVENT_ID_WIDTH-1:0] ovf_src_o,
  output logic [NB_SOURCES-1:0]     ovf_status_o,
  input  logic [NB_SOURCES-1:0]     ovf_clr_i
);

  localparam int IW = (NB_SOURCES > 1) ? $clog2(NB_SOURCES) : 1;

  if (NB_SOURCES < 1 || NB_SOURCES > 32) begin : g_bad_nb
    $error("NB_SOURCES must be within 1..32");
  end
  if (longint'(ID_BASE) + longint'(NB_SOURCES) >
      (longint'(1) << EVENT_ID_WIDTH)) begin : g_bad_id
    $error("ID_BASE+NB_SOURCES exceeds the event ID space");
  end

  logic [PEND_CNT_WIDTH-1:0] cnt [NB_SOURCES];
  logic [NB_SOURCES-1:0]     pend;
  logic [NB_SOURCES-1:0]     gnt;
  logic [NB_SOURCES-1:0]     drop;
  logic [IW-1:0]             rr_ptr;
  logic [IW-1:0]             win;
  logic [IW-1:0]             win_hi;
  logic [IW-1:0]             win_lo;
  logic [IW-1:0]             drop_idx;
  logic                      found_hi;
  logic                      load;
  logic                      do_grant;

  assign load     = !event_fifo_valid_o || event_fifo_fulln_i;
  assign do_grant = load && (|pend);

  // Lowest pending index at/after the pointer wins, else lowest overall.
  always_comb begin
    pend     = '0;
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = 0; i < NB_SOURCES; i++) begin
      pend[i] = (cnt[i] != '0);
    end
    for (int i = NB_SOURCES - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win_lo = IW'(i);
        if (i >= int'(rr_ptr)) begin
          win_hi   = IW'(i);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    gnt      = '0;
    drop     = '0;
    drop_idx = '0;
    for (int i = 0; i < NB_SOURCES; i++) begin
      gnt[i]  = do_grant && (win == IW'(i));
      drop[i] = evt_i[i] && (&cnt[i]) && !gnt[i];
    end
    for (int i = NB_SOURCES - 1; i >= 0; i--) begin
      if (drop[i]) begin
        drop_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_SOURCES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_SOURCES; i++) begin
        if (evt_i[i] && !gnt[i]) begin
          if (!(&cnt[i])) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else if (!evt_i[i] && gnt[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      event_fifo_valid_o <= 1'b0;
      event_fifo_data_o  <= '0;
      rr_ptr             <= '0;
    end else if (load) begin
      event_fifo_valid_o <= do_grant;
      if (do_grant) begin
        event_fifo_data_o <= EVENT_ID_WIDTH'(ID_BASE) +
                             EVENT_ID_WIDTH'(win);
        rr_ptr <= (win == IW'(NB_SOURCES - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      ovf_src_o  <= '0;
    end else begin
      overflow_o <= |drop;
      if (|drop) begin
        ovf_src_o <= EVENT_ID_WIDTH'(ID_BASE) +
                     EVENT_ID_WIDTH'(drop_idx);
      end
    end
  end

`ifdef FC_EVT_SER_OVF_STICKY_EN
  logic [NB_SOURCES-1:0] sticky;

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~ovf_clr_i) | drop;
    end
  end

  assign ovf_status_o = sticky;
`else
  logic unused_clr;

  assign unused_clr   = ^ovf_clr_i;
  assign ovf_status_o = '0;
`endif

endmodule

// File: tb/tb_fc_event_serializer.sv
// Scoreboard bench for fc_event_serializer: random and directed event
// streams checked against a behavioural pending-count / round-robin model.
module tb_fc_event_serializer;

  localparam int N    = 8;
  localparam int W    = 8;
  localparam int BASE = 0;
  localparam int PCW  = 2;
  localparam int MAXC = (1 << PCW) - 1;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] evt_i;
  logic         valid;
  logic [W-1:0] data;
  logic         fulln;
  logic         overflow;
  logic [W-1:0] ovf_src;
  logic [N-1:0] ovf_status;
  logic [N-1:0] ovf_clr;

  fc_event_serializer #(
    .NB_SOURCES     (N),
    .EVENT_ID_WIDTH (W),
    .ID_BASE        (BASE),
    .PEND_CNT_WIDTH (PCW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .evt_i              (evt_i),
    .event_fifo_valid_o (valid),
    .event_fifo_data_o  (data),
    .event_fifo_fulln_i (fulln),
    .overflow_o         (overflow),
    .ovf_src_o          (ovf_src),
    .ovf_status_o       (ovf_status),
    .ovf_clr_i          (ovf_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int           mcnt [N];
  int           mptr;
  logic         mvalid;
  logic         movf;
  logic [N-1:0] mstat;
  int           exp_q [$];
  int           ovf_q [$];

  logic         exp_valid_now;
  logic         exp_ovf_now;
  logic [N-1:0] exp_stat_now;
  logic         mon_en = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mptr = 0;
    mvalid = 1'b0;
    movf = 1'b0;
    mstat = '0;
    exp_q.delete();
    ovf_q.delete();
    exp_valid_now = 1'b0;
    exp_ovf_now = 1'b0;
    exp_stat_now = '0;
  endtask

  task automatic model_step(input logic [N-1:0] e, input logic f,
                            input logic [N-1:0] c);
    int g;
    logic [N-1:0] drops;
    g = -1;
    drops = '0;
    if (!mvalid || f) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (mptr + k) % N;
        if (g < 0 && mcnt[idx] > 0) g = idx;
      end
      if (g >= 0) begin
        exp_q.push_back(BASE + g);
        mvalid = 1'b1;
        mptr = (g + 1) % N;
      end else begin
        mvalid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (e[i] && g != i) begin
        if (mcnt[i] == MAXC) drops[i] = 1'b1;
        else mcnt[i]++;
      end else if (!e[i] && g == i) begin
        mcnt[i]--;
      end
    end
    movf = |drops;
    for (int i = 0; i < N; i++) begin
      if (drops[i]) begin
        ovf_q.push_back(BASE + i);
        break;
      end
    end
    mstat = (mstat & ~c) | drops;
  endtask

  task automatic step(input logic [N-1:0] e, input logic f,
                      input logic [N-1:0] c = '0);
    @(posedge clk);
    #1;
    exp_valid_now = mvalid;
    exp_ovf_now = movf;
`ifdef FC_EVT_SER_OVF_STICKY_EN
    exp_stat_now = mstat;
`else
    exp_stat_now = '0;
`endif
    evt_i = e;
    fulln = f;
    ovf_clr = c;
    model_step(e, f, c);
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) step('0, f);
  endtask

  task automatic check(input string name, input logic ok,
                       input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every cycle, pops on each transfer / overflow pulse.
  always @(negedge clk) begin
    if (mon_en && !rst_i) begin
      check("valid", valid === exp_valid_now, valid, exp_valid_now);
      if (valid && fulln) begin
        if (exp_q.size() == 0) begin
          check("unexpected_id", 1'b0, data, -1);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("data", data === W'(e), data, e);
        end
      end
      check("overflow", overflow === exp_ovf_now, overflow, exp_ovf_now);
      if (overflow) begin
        if (ovf_q.size() == 0) begin
          check("unexpected_ovf", 1'b0, ovf_src, -1);
        end else begin
          int e;
          e = ovf_q.pop_front();
          check("ovf_src", ovf_src === W'(e), ovf_src, e);
        end
      end
      check("ovf_status", ovf_status === exp_stat_now,
            ovf_status, exp_stat_now);
    end
  end

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    check("rst_valid", valid === 1'b0, valid, 0);
    check("rst_ovf", overflow === 1'b0, overflow, 0);
    check("rst_status", ovf_status === '0, ovf_status, 0);
    evt_i = '0;
    ovf_clr = '0;
    fulln = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() > 0 || mvalid); i++) begin
      step('0, 1'b1);
    end
    idle(2, 1'b1);
    check("drained", exp_q.size() == 0 && ovf_q.size() == 0,
          exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    evt_i = '0;
    fulln = 1'b1;
    ovf_clr = '0;
    model_reset();
    #23;
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_valid", valid === 1'b0, valid, 0);
    check("reset_data", data === '0, data, 0);
    check("reset_ovf", overflow === 1'b0, overflow, 0);
    check("reset_ovf_src", ovf_src === '0, ovf_src, 0);
    check("reset_status", ovf_status === '0, ovf_status, 0);
    mon_en = 1'b1;

    // single event
    idle(3, 1'b1);
    step(8'h08, 1'b1);
    idle(4, 1'b1);

    // round robin, then wrap
    step(8'hFF, 1'b1);
    idle(10, 1'b1);
    step(8'h81, 1'b1);
    idle(4, 1'b1);

    // backpressure
    step('0, 1'b0);
    step(8'h04, 1'b0);
    step('0, 1'b0);
    step(8'h04, 1'b0);
    step(8'h04, 1'b0);
    idle(4, 1'b0);
    drain();

    // overflow on source 5
    for (int i = 0; i < 5; i++) step(8'h20, 1'b0);
    idle(3, 1'b0);
    drain();

    // simultaneous increment and grant on source 1
    step(8'h02, 1'b1);
    step(8'h02, 1'b1);
    drain();

    // sticky flags: overflow two sources together, clear one
    for (int i = 0; i < 5; i++) step(8'h41, 1'b0);
    step('0, 1'b0, 8'h01);
    step(8'h01, 1'b0, 8'h01);
    idle(2, 1'b0);
    drain();
    step('0, 1'b1, 8'hFF);

    // mid-operation reset
    for (int i = 0; i < 4; i++) step(8'h3C, 1'b0);
    async_reset();
    idle(6, 1'b1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] e;
      logic         f;
      logic [N-1:0] c;
      e = N'($urandom & $urandom & $urandom);
      f = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      step(e, f, c);
      if (i == 700) async_reset();
    end
    drain();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
